mem_port_arbiter: RTL

//  Shares one single-port unified memory between the CPU's instruction-fetch port and its load/store data port.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/mem_port_arbiter_arb_pick.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the CPU memory-port arbiter: FSM states, access owner,
// and a width helper for small counters.
package cpu_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_e;
  typedef enum logic {OWN_IF, OWN_D} arb_owner_e;

  function automatic int width_for(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Winner select between fetch and data candidates, plus the starvation counter
// that lets a waiting fetch beat a stream of data grants.
module arb_pick import cpu_pkg::*; #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       if_cand,
  input  logic       d_cand,
  input  logic       if_req,
  input  logic       grant_window,
  output logic       any_req,
  output arb_owner_e winner
);

  localparam int CW = width_for(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;

  assign any_req = if_cand | d_cand;

  always_comb begin
    winner = OWN_D;
    if (if_cand && (!d_cand || starve_cnt == LIMIT)) winner = OWN_IF;
  end

  // Counts data grants taken while fetch was waiting; the raw if_req is used
  // so a grant from DONE still counts against a fetch that is pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant_window && any_req) begin
      if (winner == OWN_IF || !if_req) begin
        starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the instruction-fetch
// and load/store ports, returning data with a one-cycle ack per access.
module mem_port_arbiter import cpu_pkg::*; #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_LATENCY   = 1,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_req,
  input  logic [ADDRESS_WIDTH-1:0] if_addr,
  output logic                     if_ack,
  output logic [DATA_WIDTH-1:0]    if_rdata,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [ADDRESS_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0]    d_wdata,
  output logic                     d_ack,
  output logic [DATA_WIDTH-1:0]    d_rdata,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic                     busy,
  output logic                     stall
);

  localparam int LW = width_for(MEM_LATENCY - 1);
  localparam logic [LW-1:0] LAT_LOAD = LW'(MEM_LATENCY - 1);

  arb_state_e state, next_state;
  arb_owner_e owner, winner;
  logic [LW-1:0] lat_cnt;
  logic if_cand, d_cand, any_req, grant_window, take;

  // In DONE only the non-owner may be granted; the owner's req still belongs
  // to the access that is completing this cycle.
  always_comb begin
    if_cand      = 1'b0;
    d_cand       = 1'b0;
    grant_window = 1'b0;
    if (state == IDLE) begin
      if_cand      = if_req;
      d_cand       = d_req;
      grant_window = 1'b1;
    end else if (state == DONE) begin
      if_cand      = if_req & (owner == OWN_D);
      d_cand       = d_req & (owner == OWN_IF);
      grant_window = 1'b1;
    end
  end

  assign take = grant_window & any_req;

  arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk         (clk),
    .rst         (rst),
    .if_cand     (if_cand),
    .d_cand      (d_cand),
    .if_req      (if_req),
    .grant_window(grant_window),
    .any_req     (any_req),
    .winner      (winner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (any_req) next_state = ISSUE;
      ISSUE:   next_state = mem_we ? DONE : WAIT;
      WAIT:    if (lat_cnt == '0) next_state = DONE;
      DONE:    next_state = any_req ? ISSUE : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_req = (state == ISSUE);
    if_ack  = (state == DONE) && (owner == OWN_IF);
    d_ack   = (state == DONE) && (owner == OWN_D);
    busy    = (state != IDLE);
  end

  assign stall = (if_req & ~if_ack) | (d_req & ~d_ack);

  // Latched request fields drive the memory directly and hold between grants.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner     <= OWN_IF;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else if (take) begin
      owner <= winner;
      if (winner == OWN_D) begin
        mem_addr  <= d_addr;
        mem_we    <= d_we;
        mem_wdata <= d_wdata;
      end else begin
        mem_addr  <= if_addr;
        mem_we    <= 1'b0;
        mem_wdata <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_cnt <= '0;
    end else if (state == ISSUE) begin
      lat_cnt <= LAT_LOAD;
    end else if (state == WAIT && lat_cnt != '0) begin
      lat_cnt <= lat_cnt - LW'(1);
    end
  end

  // Stores report zero read data; loads capture the memory word on the last WAIT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata <= '0;
      d_rdata  <= '0;
    end else if (state == ISSUE && mem_we) begin
      d_rdata <= '0;
    end else if (state == WAIT && lat_cnt == '0) begin
      if (owner == OWN_IF) if_rdata <= mem_rdata;
      else                 d_rdata  <= mem_rdata;
    end
  end

endmodule
